synthesis_combiner: RTL
=======================

# synthesis_combiner

Serial synthesis stage for the 16-band non-uniform filter bank. It accepts one set of 16 band samples from the analysis bank and applies a programmable gain to each band. The weighted bands are accumulated serially through a single multiply-accumulate path, and the result is rounded and saturated back to the 14-bit input sample format. The block sits downstream of the analysis bank and returns the bank to the time domain.

## Interface
- NUM_BANDS, 16, bands summed per output sample
- BAND_W, 35, band sample width, sfix35_En32
- GAIN_W, 16, gain width, sfix16_En14
- OUT_W, 14, output width, sfix14_En12
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- clk_enable  in  1  global enable; when low, every register holds
- band_in  in  35 x 16  band samples; index 0 is band 1
- in_valid  in  1  band set present; accepted only when in_ready=1
- in_ready  out  1  high in IDLE
- gain_we  in  1  gain write strobe
- gain_addr  in  4  band index to write
- gain_data  in  16  new gain, sfix16_En14
- sample_out  out  14  reconstructed sample, sfix14_En12
- out_valid  out  1  one-enabled-cycle pulse when sample_out updates
- out_sat  out  1  high with out_valid when the result was clipped

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, latch all 16 band_in words, clear the accumulator and band counter, go to ACC.
  - ACC: one band per enabled cycle, acc += band[k] * gain[k] for k=0..15. After k=15, go to OUT.
  - OUT: round, saturate, register the output, go to IDLE.
- Arithmetic:
  - Product is 51 bits, En46.
  - Accumulator is 55 bits, En46; overflow is impossible at this width.
  - Rounding: add 2^33, then arithmetic-shift right 34 to En12. This is round-half-up, so ties round toward +inf.
  - Saturation: clip to [-8192, 8191]. out_sat=1 when clipping occurred.
- Gain registers: 16 x 16 bits, reset to 16384 (1.0).
  - A write lands at the next enabled edge, only while in_ready=1.
  - Writes while busy are dropped silently, so the gains used for one sample never change mid-sample.
- in_valid while busy is ignored. The source must hold the band set until it sees in_ready=1.
- In the OUT cycle, in_ready is low. IDLE is re-entered on the same edge that raises out_valid.

## Timing
- Reset values: sample_out=0, out_valid=0, out_sat=0, in_ready=1, state=IDLE, accumulator=0, all gains 16384.
- in_valid accepted at enabled edge E.
- in_ready is low for enabled edges E+1..E+17 inclusive.
- out_valid goes high after enabled edge E+17 and falls at the next enabled edge. Latency is 17 enabled cycles.
- Back-to-back: a new in_valid may be accepted in the out_valid cycle. Maximum throughput is one sample per 17 enabled cycles.
- clk_enable low: state, counter, accumulator and outputs freeze. A pending out_valid stays high until the next enabled edge.
- Reset mid-operation: the partial accumulation is discarded, outputs return to reset values, and no out_valid is emitted for the aborted set.

## Structure
- Shared package synth_pkg:
  - width constants: BAND_W, GAIN_W, ACC_W=55, OUT_W, ROUND_SHIFT=34
  - GAIN_ONE=16384
  - state enum {IDLE, ACC, OUT}
  - OUT_MAX=8191, OUT_MIN=-8192
- One sub-module, combiner_mac: a registered signed 35x16 multiply-accumulate with clear and enable.
- The top level holds the FSM, band latch, gain file and round/saturate logic.

## Test plan
- band[0]=2^32, others 0, default gains -> sample_out=4096, out_sat=0, out_valid exactly 17 enabled cycles after accept.
- band[0]=2^19 -> 1. band[0]=-2^19 -> 0, confirming half-up rounding. band[0]=-3*2^32 -> -8192 with out_sat=1.
- All bands=2^30, unity gains (sum 4.0) -> 8191, out_sat=1. Then write gain[k]=2048 (0.125) for all k -> 2048, out_sat=0.
- gain_we for band 0 with value 0 issued during ACC -> ignored. Output uses the old gain; a later IDLE write takes effect on the next sample.
- Two band sets, second in_valid held from the out_valid cycle: second accepted immediately, outputs 17 cycles apart. Toggle clk_enable low for 5 cycles mid-ACC -> latency stretches by exactly 5 cycles, value unchanged.
- Assert reset at ACC band 7 -> all outputs at reset values, no out_valid, in_ready=1 after release, gains back to 16384.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants, state encoding and rounding helper for the synthesis combiner.
package synth_pkg;

    localparam int unsigned NUM_BANDS   = 16;
    localparam int unsigned BAND_W      = 35;  // sfix35_En32
    localparam int unsigned GAIN_W      = 16;  // sfix16_En14
    localparam int unsigned PROD_W      = BAND_W + GAIN_W;  // En46
    localparam int unsigned ACC_W       = 55;  // En46, 4 guard bits over the product
    localparam int unsigned OUT_W       = 14;  // sfix14_En12
    localparam int unsigned ROUND_SHIFT = 34;  // En46 -> En12
    localparam int unsigned RND_W       = ACC_W - ROUND_SHIFT;
    localparam int unsigned CNT_W       = $clog2(NUM_BANDS);

    localparam logic signed [GAIN_W-1:0] GAIN_ONE = 16'sd16384;
    localparam int OUT_MAX = 8191;
    localparam int OUT_MIN = -8192;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_e;

    // Round half-up (toward +inf on ties) from En46 down to En12.
    function automatic logic signed [RND_W-1:0] round_en12(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] biased;
        biased = acc + (ACC_W'(1) << (ROUND_SHIFT - 1));
        return biased[ACC_W-1:ROUND_SHIFT];
    endfunction

endpackage

// File: rtl/synthesis_combiner_if.sv
// Band-set input, gain write port and reconstructed-sample output of the combiner.
interface synthesis_combiner_if;
    import synth_pkg::*;

    logic [NUM_BANDS-1:0][BAND_W-1:0] band_in;
    logic                             in_valid;
    logic                             in_ready;
    logic                             gain_we;
    logic [CNT_W-1:0]                 gain_addr;
    logic [GAIN_W-1:0]                gain_data;
    logic [OUT_W-1:0]                 sample_out;
    logic                             out_valid;
    logic                             out_sat;

    modport master (
        output band_in, in_valid, gain_we, gain_addr, gain_data,
        input  in_ready, sample_out, out_valid, out_sat
    );

    modport slave (
        input  band_in, in_valid, gain_we, gain_addr, gain_data,
        output in_ready, sample_out, out_valid, out_sat
    );

endinterface

// File: rtl/combiner_mac.sv
// Registered signed 35x16 multiply-accumulate with synchronous clear.
module combiner_mac
    import synth_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic                     clear,
    input  logic                     acc_en,
    input  logic signed [BAND_W-1:0] band,
    input  logic signed [GAIN_W-1:0] gain,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    // Full-precision product and next accumulator value; clear wins over accumulate.
    always_comb begin
        prod  = PROD_W'(band) * PROD_W'(gain);
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register, frozen while clk_enable is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clk_enable) begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/synthesis_combiner.sv
// Serial 16-band synthesis: latch a band set, weight and sum it through one MAC,
// then round and saturate to the 14-bit sample format.
module synthesis_combiner
    import synth_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clk_enable,
    synthesis_combiner_if.slave  bus
);

    localparam logic signed [RND_W-1:0] RND_MAX = RND_W'(OUT_MAX);
    localparam logic signed [RND_W-1:0] RND_MIN = RND_W'(OUT_MIN);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [BAND_W-1:0]  band_q [NUM_BANDS];
    logic signed [GAIN_W-1:0]  gain_q [NUM_BANDS];
    logic signed [OUT_W-1:0]   sample_q, sample_d;
    logic                      out_valid_q, out_sat_q, out_sat_d;

    logic                      latch;
    logic                      mac_clear;
    logic                      mac_en;
    logic                      out_load;
    logic                      gain_wr;
    logic signed [ACC_W-1:0]   acc;
    logic signed [RND_W-1:0]   rnd;

    combiner_mac u_mac (
        .clock      (clock),
        .reset      (reset),
        .clk_enable (clk_enable),
        .clear      (mac_clear),
        .acc_en     (mac_en),
        .band       (band_q[cnt_q]),
        .gain       (gain_q[cnt_q]),
        .acc        (acc)
    );

    // Next-state and control decode for IDLE -> ACC (16 bands) -> OUT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        out_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    latch     = 1'b1;
                    mac_clear = 1'b1;
                    cnt_d     = '0;
                    state_d   = ACC;
                end
            end
            ACC: begin
                mac_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_BANDS - 1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_load = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Round the finished sum and clip it into the output range.
    always_comb begin
        rnd       = round_en12(acc);
        out_sat_d = 1'b0;
        sample_d  = rnd[OUT_W-1:0];
        if (rnd > RND_MAX) begin
            sample_d  = OUT_W'(OUT_MAX);
            out_sat_d = 1'b1;
        end else if (rnd < RND_MIN) begin
            sample_d  = OUT_W'(OUT_MIN);
            out_sat_d = 1'b1;
        end
    end

    // FSM, band counter and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sample_q    <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else if (clk_enable) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_load;
            if (out_load) begin
                sample_q  <= sample_d;
                out_sat_q <= out_sat_d;
            end
        end
    end

    // Gains only change while idle, so a sample never mixes old and new gains.
    assign gain_wr = bus.gain_we && (state_q == IDLE);

    // Band latch and gain file.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                band_q[i] <= '0;
                gain_q[i] <= GAIN_ONE;
            end
        end else if (clk_enable) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                if (latch) begin
                    band_q[i] <= $signed(bus.band_in[i]);
                end
                if (gain_wr && (bus.gain_addr == CNT_W'(i))) begin
                    gain_q[i] <= $signed(bus.gain_data);
                end
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.sample_out = sample_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sat    = out_sat_q;

endmodule
